// File: rtl/sga_pkg.sv
// Shared constants, direction encoding and FSM state type for the snake body writer.
package sga_pkg;

  localparam int unsigned POS_W    = 4;
  localparam int unsigned MAX_SIZE = 16;
  localparam int unsigned IDX_W    = $clog2(MAX_SIZE);

  localparam logic [POS_W-1:0] INIT_HEAD = 4'b0101;

  // Encoding matches the button bit index, so a pressed bit maps straight to a direction.
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StHead,
    StCheck,
    StDone
  } state_t;

  function automatic dir_t dir_reverse(input dir_t dir);
    unique case (dir)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/sga_next_head.sv
// Steps the snake head one cell in the given direction on the 4x4 grid.
// SGA_WRAP_EN: wrap modulo 4 per axis; when undefined, off_edge flags a move off the grid.
module sga_next_head
  import sga_pkg::*;
(
  input  logic [POS_W-1:0] head,
  input  dir_t             dir,
  output logic [POS_W-1:0] next_head,
  output logic             off_edge
);

`ifdef SGA_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic [1:0] row, col, row_next, col_next;

  assign row = head[3:2];
  assign col = head[1:0];

  // 2-bit axis arithmetic wraps naturally; the edge flag decides whether that is legal.
  always_comb begin
    row_next = row;
    col_next = col;
    off_edge = 1'b0;
    unique case (dir)
      DIR_UP: begin
        row_next = row - 2'd1;
        off_edge = !WrapEn && (row == 2'd0);
      end
      DIR_DOWN: begin
        row_next = row + 2'd1;
        off_edge = !WrapEn && (row == 2'd3);
      end
      DIR_LEFT: begin
        col_next = col - 2'd1;
        off_edge = !WrapEn && (col == 2'd0);
      end
      DIR_RIGHT: begin
        col_next = col + 2'd1;
        off_edge = !WrapEn && (col == 2'd3);
      end
    endcase
  end

  assign next_head = {row_next, col_next};

endmodule

// File: rtl/sga_body_writer.sv
// Snake body store and movement engine: shifts the body, places the new head, scans for self-hit.
// Edge behaviour is selected by SGA_WRAP_EN inside sga_next_head.
module sga_body_writer
  import sga_pkg::*;
(
  input  logic             clock,
  input  logic             restart_n,
  input  logic [3:0]       buttons,
  input  logic             move,
  input  logic             grow,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [POS_W-1:0] rd_data,
  output logic [IDX_W-1:0] size,
  output logic             busy,
  output logic             done,
  output logic             collision
);

  state_t           state_q, state_d;
  logic [POS_W-1:0] mem_q [MAX_SIZE];
  logic [POS_W-1:0] rd_data_q;
  logic [IDX_W-1:0] size_q, size_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  dir_t             dir_q, dir_d;
  logic             grow_q, grow_d;
  logic             coll_q, coll_d;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [POS_W-1:0] mem_wdata;
  logic [IDX_W-1:0] idx_prev;

  logic [POS_W-1:0] next_head;
  logic             off_edge;
  logic             req_valid;
  dir_t             req_dir;

  sga_next_head u_next_head (
    .head      (mem_q[0]),
    .dir       (dir_q),
    .next_head (next_head),
    .off_edge  (off_edge)
  );

  // Lowest set button wins.
  always_comb begin
    req_valid = |buttons;
    req_dir   = dir_q;
    if (buttons[0]) begin
      req_dir = DIR_UP;
    end else if (buttons[1]) begin
      req_dir = DIR_DOWN;
    end else if (buttons[2]) begin
      req_dir = DIR_LEFT;
    end else if (buttons[3]) begin
      req_dir = DIR_RIGHT;
    end
  end

  assign idx_prev = idx_q - IDX_W'(1);

  // idx_q is the shift write pointer in StShift and the compare pointer in StCheck.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    grow_d    = grow_q;
    coll_d    = coll_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = mem_q[idx_prev];

    unique case (state_q)
      StIdle: begin
        if (move) begin
          if (req_valid && !((size_q != '0) && (req_dir == dir_reverse(dir_q)))) begin
            dir_d = req_dir;
          end
          grow_d  = grow && (size_q != IDX_W'(MAX_SIZE - 1));
          idx_d   = size_q + IDX_W'(grow_d);
          state_d = (idx_d != '0) ? StShift : StHead;
        end
      end
      StShift: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = mem_q[idx_prev];
        idx_d     = idx_prev;
        if (idx_q == IDX_W'(1)) begin
          state_d = StHead;
        end
      end
      StHead: begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        // Off the edge the head is rewritten in place; the shift stays committed.
        mem_wdata = off_edge ? mem_q[0] : next_head;
        if (off_edge) begin
          coll_d = 1'b1;
        end
        if (grow_q) begin
          size_d = size_q + IDX_W'(1);
        end
        idx_d   = IDX_W'(1);
        state_d = (size_d != '0) ? StCheck : StDone;
      end
      StCheck: begin
        if (mem_q[idx_q] == mem_q[0]) begin
          coll_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == size_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= StIdle;
      size_q  <= '0;
      idx_q   <= '0;
      dir_q   <= DIR_RIGHT;
      grow_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      coll_q  <= coll_d;
    end
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      for (int i = 1; i < MAX_SIZE; i++) begin
        mem_q[i] <= '0;
      end
      mem_q[0]  <= INIT_HEAD;
      rd_data_q <= '0;
    end else begin
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign size      = size_q;
  assign busy      = (state_q == StShift) || (state_q == StHead) || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign collision = coll_q;

endmodule

// File: tb/tb_sga_body_writer.sv
// Directed bench for sga_body_writer with a cycle-level reference model of each step.
module tb_sga_body_writer;

  logic       clock;
  logic       restart_n;
  logic [3:0] buttons;
  logic       move;
  logic       grow;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] size;
  logic       busy;
  logic       done;
  logic       collision;

  int checks = 0;
  int errors = 0;

  sga_body_writer dut (
    .clock     (clock),
    .restart_n (restart_n),
    .buttons   (buttons),
    .move      (move),
    .grow      (grow),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Directions: 0 up, 1 down, 2 left, 3 right (same as button bit index).
  logic [3:0] m_mem [16];
  int m_len, m_dir, m_L, m_Lp, m_H, m_hit, m_done_cyc, m_cyc;
  bit m_active, m_coll, m_coll_before;

  localparam int NoHit = 1000;

  function automatic int rev_dir(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
    m_mem[0] = 4'b0101;
    m_len = 1;
    m_dir = 3;
    m_coll = 0;
    m_coll_before = 0;
    m_active = 0;
    m_cyc = 0;
  endtask

  task automatic model_accept();
    int req, g;
    logic [1:0] r, c;
    bit off;
    logic [3:0] nh;
    req = -1;
    for (int i = 3; i >= 0; i--) if (buttons[i]) req = i;
    if (req >= 0 && !(m_len > 1 && req == rev_dir(m_dir))) m_dir = req;
    g = (grow && m_len < 16) ? 1 : 0;
    m_L = m_len;
    m_Lp = m_len + g;
    m_H = m_Lp;
    m_done_cyc = 2 * m_Lp;
    r = m_mem[0][3:2];
    c = m_mem[0][1:0];
    off = 0;
    case (m_dir)
      0: begin off = (r == 0); r = r - 1; end
      1: begin off = (r == 3); r = r + 1; end
      2: begin off = (c == 0); c = c - 1; end
      default: begin off = (c == 3); c = c + 1; end
    endcase
`ifdef SGA_WRAP_EN
    off = 0;
`endif
    nh = off ? m_mem[0] : {r, c};
    for (int i = m_Lp - 1; i >= 1; i--) m_mem[i] = m_mem[i-1];
    m_mem[0] = nh;
    m_hit = NoHit;
    if (off) m_hit = m_H;
    else
      for (int k = 1; k < m_Lp; k++)
        if (m_hit == NoHit && m_mem[k] == m_mem[0]) m_hit = m_H + k;
    m_coll_before = m_coll;
    m_coll = m_coll || (m_hit != NoHit);
    m_len = m_Lp;
    m_cyc = 1;
    m_active = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge restart_n);
      if (!restart_n) model_reset();
      else if (m_active) begin
        if (m_cyc == m_done_cyc) m_active = 0;
        else m_cyc++;
      end else if (move) model_accept();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!restart_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_size", size, 0);
        chk("rst_coll", collision, 0);
        chk("rst_rd_data", rd_data, 0);
      end else if (m_active) begin
        chk("cyc_busy", busy, (m_cyc >= 1 && m_cyc < m_done_cyc));
        chk("cyc_done", done, (m_cyc == m_done_cyc));
        chk("cyc_size", size, (m_cyc > m_H) ? m_Lp - 1 : m_L - 1);
        chk("cyc_coll", collision, (m_coll_before || (m_cyc > m_hit)));
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_size", size, m_len - 1);
        chk("idle_coll", collision, m_coll);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clock);
    restart_n = 1'b0;
    repeat (2) @(negedge clock);
    restart_n = 1'b1;
  endtask

  task automatic step(input logic [3:0] b, input logic g, output int n);
    @(negedge clock);
    buttons = b;
    grow = g;
    move = 1'b1;
    @(negedge clock);
    move = 1'b0;
    grow = 1'b0;
    buttons = 4'h0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("step_done_seen", done, 1);
    @(negedge clock);
  endtask

  task automatic rd(input int a, output logic [3:0] d);
    @(negedge clock);
    rd_addr = 4'(a);
    @(negedge clock);
    d = rd_data;
  endtask

  task automatic read_all();
    logic [3:0] d;
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      chk($sformatf("mem[%0d]", i), d, m_mem[i]);
    end
  endtask

  logic [3:0] spiral [17] = '{4'h8, 4'h8, 4'h2, 4'h2, 4'h4, 4'h4, 4'h1, 4'h8, 4'h8,
                              4'h2, 4'h4, 4'h1, 4'h8, 4'h2, 4'h4, 4'h1, 4'h3};

  initial begin
    int n, nd;
    logic [3:0] d;
    restart_n = 1'b0;
    buttons = 4'h0;
    move = 1'b0;
    grow = 1'b0;
    rd_addr = 4'h0;
    repeat (3) @(negedge clock);
    chk("lit_rst_size", size, 0);
    restart_n = 1'b1;
    rd(0, d);
    chk("lit_rst_head", d, 4'b0101);
    read_all();

    // No buttons: default right.
    step(4'h0, 1'b0, n);
    chk("lit_done_cycle_L1", n, 2);
    rd(0, d);
    chk("lit_head_right", d, 4'b0110);
    chk("lit_size0", size, 0);
    chk("lit_coll0", collision, 0);

    // Up with grow, then reverse request.
    do_reset();
    step(4'b0001, 1'b1, n);
    chk("lit_done_cycle_grow", n, 4);
    chk("lit_size1", size, 1);
    rd(0, d);
    chk("lit_head_up", d, 4'b0001);
    rd(1, d);
    chk("lit_body1", d, 4'b0101);
    step(4'b0010, 1'b0, n);
    rd(0, d);
`ifdef SGA_WRAP_EN
    chk("lit_rev_head_wrap", d, 4'b1101);
    chk("lit_rev_coll_wrap", collision, 0);
`else
    chk("lit_rev_head_wall", d, 4'b0001);
    chk("lit_rev_coll_wall", collision, 1);
`endif
    read_all();

    // Four rightward grow steps.
    do_reset();
    step(4'b1000, 1'b1, n);
    step(4'b1000, 1'b1, n);
    step(4'b1000, 1'b1, n);
`ifdef SGA_WRAP_EN
    chk("lit_third_coll", collision, 0);
`else
    chk("lit_third_coll", collision, 1);
`endif
    step(4'b1000, 1'b1, n);
    chk("lit_fourth_size", size, 4);
    chk("lit_fourth_coll", collision, 1);
    read_all();

    // move while busy is ignored.
    do_reset();
    step(4'b1000, 1'b1, n);
    nd = 0;
    @(negedge clock);
    move = 1'b1;
    for (int i = 1; i < 14; i++) begin
      @(negedge clock);
      move = (i == 2);
      if (done) nd++;
    end
    move = 1'b0;
    chk("lit_one_done", nd, 1);
    chk("lit_busy_size", size, 1);
    rd(0, d);
    chk("lit_busy_head", d, 4'b0111);

    // Reset in the middle of CHECK.
    do_reset();
    step(4'h0, 1'b1, n);
    @(negedge clock);
    grow = 1'b1;
    move = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      move = 1'b0;
      grow = 1'b0;
    end
    chk("lit_busy_in_check", busy, 1);
    #2 restart_n = 1'b0;
    #1;
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_size", size, 0);
    chk("lit_abort_coll", collision, 0);
    chk("lit_abort_done", done, 0);
    chk("lit_abort_rd", rd_data, 0);
    @(negedge clock);
    restart_n = 1'b1;
    rd(0, d);
    chk("lit_abort_head", d, 4'b0101);

    // Long directed walk growing past the maximum length.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(spiral[i], 1'b1, n);
      read_all();
    end
    chk("lit_max_size", size, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sga_body_writer.md
# sga_body_writer

Snake body memory and movement engine for the Snake Game Arcade. It is the write side of the snake-position store that the render path reads from: on each `move` pulse it shifts the body one segment, computes the new head from the button direction, optionally grows, and scans the body for self-collision. The render path reads positions through a synchronous read port; the block replaces the fixed body ROM in the datapath.

## Interface
- `POS_W`, 4: position width as {row[1:0], col[1:0]} on a 4x4 grid.
- `MAX_SIZE`, 16: body entries, which is also the maximum length.
- `clock` in 1: rising-edge clock.
- `restart_n` in 1: reset, asynchronous and active-low.
- `buttons` in 4: direction request. Bit 0 = up, 1 = down, 2 = left, 3 = right.
- `move` in 1: one-cycle pulse that requests one step.
- `grow` in 1: apple eaten. Sampled together with `move`.
- `rd_addr` in 4: read address for the render path. Index 0 is the head.
- `rd_data` out 4: registered `mem[rd_addr]`.
- `size` out 4: current length minus 1. Length is 1 to 16.
- `busy` out 1: high while a step is in progress.
- `done` out 1: one-cycle pulse when a step completes.
- `collision` out 1: sticky. Set on self-hit (or wall hit, see Configuration).

## Operation
- Reset values:
  - `mem[0]` = 4'b0101, all other entries = 0.
  - `size` = 0, direction = right.
  - `busy`, `done`, `collision`, `rd_data` = 0.
- Direction latch:
  - Updates in IDLE when `move` is accepted.
  - With several buttons pressed, the lowest set bit wins. With no button pressed, the previous direction is kept.
  - When length > 1, a request for the exact reverse of the current direction is ignored.
- Next head, computed from `mem[0]` and the latched direction:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Arithmetic is 2-bit per axis.
- FSM states: IDLE, SHIFT, HEAD, CHECK, DONE.
- IDLE
  - On `move`, latch `g = grow && size != 15`. Grow at maximum length is ignored.
  - Set `idx = size + g`.
  - Go to SHIFT if `idx > 0`, otherwise go to HEAD.
- SHIFT
  - Each cycle: `mem[idx] <= mem[idx-1]`, then `idx--`.
  - When the write was to `idx == 1`, go to HEAD.
- HEAD
  - `mem[0] <= next head`. If `g`, `size <= size + 1`.
  - Go to CHECK with `cidx = 1` if the new length > 1, otherwise go to DONE.
- CHECK
  - If `mem[cidx] == mem[0]`, set `collision`.
  - Increment `cidx`. Go to DONE after checking `cidx == size`.
- DONE
  - Assert `done` for one cycle, then return to IDLE.
- `move` in any state other than IDLE is ignored, with no queueing.
- `collision` is cleared only by `restart_n`. Steps continue after a collision; halting the game is the controller's job.
- Read port:
  - `rd_data` updates every cycle, independent of the FSM.
  - Reads while `busy` return partially shifted data. The renderer must read only while `!busy`.

## Timing
- The `move` edge is cycle 0. Let L = old length, g = grow flag, L' = L + g.
- SHIFT occupies L - 1 + g cycles.
- HEAD occupies 1 cycle.
- CHECK occupies L' - 1 cycles.
- `done` is high in cycle (L - 1 + g) + (L' - 1) + 2. Examples:
  - L = 1, g = 0: cycle 2.
  - L = 1, g = 1: cycle 4.
- `busy` is high from cycle 1 through the last CHECK or HEAD cycle. `busy` is low in DONE.
- `size` updates at the end of HEAD.
- `collision` rises at the end of the matching CHECK cycle.
- `rd_data` latency is 1 cycle from `rd_addr`.
- Asserting `restart_n` low mid-step aborts immediately to the reset values. There is no partial-commit guarantee.

## Configuration
- `SGA_WRAP_EN` defined:
  - The head wraps modulo 4 on each axis, e.g. row 0 moving up goes to row 3.
- `SGA_WRAP_EN` undefined:
  - A move off the grid edge sets `collision` in HEAD.
  - `mem[0]` is rewritten with its old value, so the head stays in place. The shift has already happened and is not undone.
  - The step still completes with `done`.

## Structure
- Package `sga_pkg` holds:
  - `POS_W`, `MAX_SIZE`, `INIT_HEAD` (4'b0101).
  - Direction encoding constants `DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT`.
  - The FSM state typedef.
- One combinational sub-module, `sga_next_head`: current head plus direction in, next head and off-edge flag out. The `SGA_WRAP_EN` behaviour lives in this sub-module.

## Test plan
- Reset, then `move` with `buttons` = 0 → `done` at cycle 2, `mem[0]` = 4'b0110, `size` = 0, `collision` = 0.
- From reset, `buttons` = 4'b0001 with `move` and `grow` → `done` at cycle 4, `size` = 1, `mem[0]` = 4'b0001, `mem[1]` = 4'b0101.
- Then `buttons` = 4'b0010 (reverse) with `move` → direction stays up.
  - With `SGA_WRAP_EN`: `mem[0]` = 4'b1101.
  - Without `SGA_WRAP_EN`: `collision` = 1 and `mem[0]` = 4'b0001.
- With `SGA_WRAP_EN`, from reset, four rightward `move`+`grow` steps:
  - Third `done` has `collision` = 0.
  - Fourth `done` has `size` = 4 and `collision` = 1, because the head 4'b0101 matches `mem[4]`.
- `move` pulsed while `busy` → ignored. Exactly one `done` per accepted step; `size` is unchanged by the ignored pulse.
- `restart_n` low during CHECK → outputs return to reset values asynchronously, and `mem[0]` reads back 4'b0101 after release.
